// File: rtl/pipe_pkg.sv
// Shared types, limits and helpers for the elastic vector pipe.
package pipe_pkg;

    // Upper bound on stage count: the ready chain ripples combinationally
    // through every stage, so depth is capped to keep that path short.
    localparam int MAX_STAGES = 16;

    // Per-stage control bundle: incoming valid and squash.
    typedef struct packed {
        logic valid;
        logic flush;
    } pipe_ctrl_t;

    // Width of an occupancy counter for n stages (at least one bit).
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// One elastic pipeline stage: valid bit plus payload register.
// rdy_in is the ready of the stage downstream; rdy_out is this stage's ready
// reported upstream. An empty stage is always ready (bubble collapsing).
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int RESET_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  pipe_ctrl_t        ctrl,
    input  logic [DWIDTH-1:0] d_in,
    input  logic              rdy_in,
    output logic              rdy_out,
    output logic              v_out,
    output logic [DWIDTH-1:0] d_out
);

    logic              v_reg;
    logic              v_next;
    logic [DWIDTH-1:0] d_reg;
    logic [DWIDTH-1:0] d_next;

    assign rdy_out = ~v_reg | rdy_in;
    assign v_out   = v_reg;
    assign d_out   = d_reg;

    // Next state: load when ready (payload only with a valid item), squash wins.
    always_comb begin
        v_next = v_reg;
        d_next = d_reg;
        if (rdy_out) begin
            v_next = ctrl.valid;
            if (ctrl.valid) begin
                d_next = d_in;
            end
        end
        if (ctrl.flush) begin
            v_next = 1'b0;
        end
    end

    // Valid bit register; reset empties the stage immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_reg <= 1'b0;
        end else begin
            v_reg <= v_next;
        end
    end

    generate
        if (RESET_DATA != 0) begin : g_data_rst
            // Payload register cleared on reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    d_reg <= '0;
                end else begin
                    d_reg <= d_next;
                end
            end
        end else begin : g_data_norst
            // Payload register without reset; qualified by the valid bit.
            always_ff @(posedge clk) begin
                d_reg <= d_next;
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_vec_elastic.sv
// N-stage elastic pipe with valid/ready back-pressure, bubble collapsing,
// synchronous flush and occupancy count. N=0 degenerates to a wire.
module pipe_vec_elastic
    import pipe_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int N          = 2,
    parameter int RESET_DATA = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [DWIDTH-1:0]         i_data,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [DWIDTH-1:0]         o_data,
    input  logic                      i_flush,
    output logic [count_width(N)-1:0] o_count
);

    localparam int CW = count_width(N);

    generate
        if (N == 0) begin : g_pass
            // Combinational pass-through; clock and reset are not needed.
            logic unused_clk_reset;
            assign unused_clk_reset = &{1'b0, clk, reset};

            assign o_valid = i_valid & ~i_flush;
            assign o_data  = i_data;
            assign i_ready = o_ready & ~i_flush;
            assign o_count = '0;
        end else begin : g_pipe
            logic [N:0]             rdy;
            logic [N-1:0]           v;
            logic [N-1:0][DWIDTH-1:0] d;
            logic [CW-1:0]          count_next;

            assign rdy[N]  = o_ready;
            assign i_ready = rdy[0] & ~i_flush;
            assign o_valid = v[N-1];
            assign o_data  = d[N-1];

            for (genvar gi = 0; gi < N; gi++) begin : g_stage
                pipe_ctrl_t        ctrl;
                logic [DWIDTH-1:0] d_src;

                if (gi == 0) begin : g_head
                    assign ctrl  = '{valid: i_valid & ~i_flush, flush: i_flush};
                    assign d_src = i_data;
                end else begin : g_body
                    assign ctrl  = '{valid: v[gi-1], flush: i_flush};
                    assign d_src = d[gi-1];
                end

                pipe_stage_elastic #(
                    .DWIDTH     (DWIDTH),
                    .RESET_DATA (RESET_DATA)
                ) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .ctrl    (ctrl),
                    .d_in    (d_src),
                    .rdy_in  (rdy[gi+1]),
                    .rdy_out (rdy[gi]),
                    .v_out   (v[gi]),
                    .d_out   (d[gi])
                );
            end

            // Occupancy: population count of the stage valid bits.
            always_comb begin
                count_next = '0;
                for (int k = 0; k < N; k++) begin
                    count_next = count_next + CW'(v[k]);
                end
            end

            assign o_count = count_next;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_vec_elastic.sv
// Self-checking bench for pipe_vec_elastic: four configurations
// (N=3, N=4, N=2 with data reset, N=0) with scoreboards on N=3 and N=4.
module tb_pipe_vec_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // N=3 instance
    logic       a_iv, a_ir, a_ov, a_or, a_fl;
    logic [7:0] a_id, a_od;
    logic [1:0] a_cnt;
    // N=4 instance
    logic       b_iv, b_ir, b_ov, b_or, b_fl;
    logic [7:0] b_id, b_od;
    logic [2:0] b_cnt;
    // N=2, RESET_DATA=1 instance
    logic       c_iv, c_ir, c_ov, c_or, c_fl;
    logic [7:0] c_id, c_od;
    logic [1:0] c_cnt;
    // N=0 instance
    logic       z_iv, z_ir, z_ov, z_or, z_fl;
    logic [7:0] z_id, z_od;
    logic [0:0] z_cnt;

    pipe_vec_elastic #(.DWIDTH(8), .N(3), .RESET_DATA(0)) u_a (
        .clk(clk), .reset(reset), .i_valid(a_iv), .i_ready(a_ir), .i_data(a_id),
        .o_valid(a_ov), .o_ready(a_or), .o_data(a_od), .i_flush(a_fl), .o_count(a_cnt));
    pipe_vec_elastic #(.DWIDTH(8), .N(4), .RESET_DATA(0)) u_b (
        .clk(clk), .reset(reset), .i_valid(b_iv), .i_ready(b_ir), .i_data(b_id),
        .o_valid(b_ov), .o_ready(b_or), .o_data(b_od), .i_flush(b_fl), .o_count(b_cnt));
    pipe_vec_elastic #(.DWIDTH(8), .N(2), .RESET_DATA(1)) u_c (
        .clk(clk), .reset(reset), .i_valid(c_iv), .i_ready(c_ir), .i_data(c_id),
        .o_valid(c_ov), .o_ready(c_or), .o_data(c_od), .i_flush(c_fl), .o_count(c_cnt));
    pipe_vec_elastic #(.DWIDTH(8), .N(0), .RESET_DATA(0)) u_z (
        .clk(clk), .reset(reset), .i_valid(z_iv), .i_ready(z_ir), .i_data(z_id),
        .o_valid(z_ov), .o_ready(z_or), .o_data(z_od), .i_flush(z_fl), .o_count(z_cnt));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] a_q[$];
    logic [7:0] b_q[$];

    // Scoreboard for N=3: compare outputs, record accepted inputs, drop on flush.
    always @(negedge clk) begin
        if (reset) begin
            a_q.delete();
        end else begin
            if (a_ov && a_or) begin
                $display("a out data=0x%02h", a_od);
                if (a_q.size() == 0) check_eq("a_sb_nonempty", a_q.size(), 1);
                else check_eq("a_out_data", a_od, a_q.pop_front());
            end
            if (a_iv && a_ir) begin
                $display("a in  data=0x%02h", a_id);
                a_q.push_back(a_id);
            end
            if (a_fl) a_q.delete();
        end
    end

    // Scoreboard for N=4.
    always @(negedge clk) begin
        if (reset) begin
            b_q.delete();
        end else begin
            if (b_ov && b_or) begin
                $display("b out data=0x%02h", b_od);
                if (b_q.size() == 0) check_eq("b_sb_nonempty", b_q.size(), 1);
                else check_eq("b_out_data", b_od, b_q.pop_front());
            end
            if (b_iv && b_ir) begin
                $display("b in  data=0x%02h", b_id);
                b_q.push_back(b_id);
            end
            if (b_fl) b_q.delete();
        end
    end

    // N=0 stimulus table: valid, ready, flush, data, expected o_valid, expected i_ready
    logic       z_tv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       z_tr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       z_tf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] z_td [4] = '{8'h5A, 8'hC3, 8'h0F, 8'h77};
    logic       z_eov[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       z_eir[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        a_iv = 0; a_or = 1; a_fl = 0; a_id = '0;
        b_iv = 0; b_or = 1; b_fl = 0; b_id = '0;
        c_iv = 0; c_or = 1; c_fl = 0; c_id = '0;
        z_iv = 0; z_or = 1; z_fl = 0; z_id = '0;
        repeat (2) tick();

        // Reset state
        check_eq("rst_a_ovalid", a_ov, 0);
        check_eq("rst_a_count", a_cnt, 0);
        check_eq("rst_a_iready", a_ir, 1);
        check_eq("rst_c_odata", c_od, 0);
        reset = 1'b0;

        // T1: N=3 back-to-back stream 0x01..0x05
        for (int e = 1; e <= 8; e++) begin
            int acc, outs;
            a_iv = (e <= 5);
            a_id = 8'(e);
            tick();
            acc  = (e < 5) ? e : 5;
            outs = e - 3;
            if (outs < 0) outs = 0;
            if (outs > 5) outs = 5;
            check_eq("t1_count", a_cnt, acc - outs);
            check_eq("t1_ovalid", a_ov, (e >= 3 && e <= 7));
        end
        a_iv = 0;

        // T2: N=3 fill while stalled, then one simultaneous in/out
        a_or = 0;
        for (int k = 0; k < 3; k++) begin
            a_iv = 1; a_id = 8'h11 + 8'(k);
            tick();
        end
        a_id = 8'h14;
        #1;
        check_eq("t2_full_count", a_cnt, 3);
        check_eq("t2_full_iready", a_ir, 0);
        a_or = 1;
        #1;
        check_eq("t2_pass_iready", a_ir, 1);
        tick();
        a_or = 0; a_iv = 0;
        check_eq("t2_after_count", a_cnt, 3);
        check_eq("t2_head_data", a_od, 8'h12);
        a_or = 1;
        repeat (4) tick();
        check_eq("t2_drained", a_cnt, 0);

        // T3: N=4 bubbles collapse behind a stalled output
        b_or = 0;
        for (int k = 0; k < 9; k++) begin
            b_iv = (k == 0 || k == 3);
            b_id = (k == 0) ? 8'h21 : 8'h22;
            tick();
        end
        b_iv = 0;
        check_eq("t3_count", b_cnt, 2);
        check_eq("t3_iready", b_ir, 1);
        check_eq("t3_ovalid", b_ov, 1);
        check_eq("t3_head", b_od, 8'h21);
        b_or = 1;
        repeat (3) tick();
        check_eq("t3_drained", b_cnt, 0);

        // T4: N=3 flush with items in flight
        a_or = 0;
        a_iv = 1; a_id = 8'hA1; tick();
        a_id = 8'hA2; tick();
        a_iv = 0; tick();
        check_eq("t4_pre_ovalid", a_ov, 1);
        check_eq("t4_pre_count", a_cnt, 2);
        a_iv = 1; a_id = 8'hFF; a_fl = 1;
        #1;
        check_eq("t4_flush_iready", a_ir, 0);
        check_eq("t4_flush_ovalid", a_ov, 1);
        tick();
        a_fl = 0; a_iv = 0;
        check_eq("t4_post_ovalid", a_ov, 0);
        check_eq("t4_post_count", a_cnt, 0);
        a_or = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t4_no_ff", a_ov, 0);
        end

        // T5: N=2 RESET_DATA=1, asynchronous reset between edges
        c_or = 1;
        for (int k = 0; k < 3; k++) begin
            c_iv = 1; c_id = 8'h31 + 8'(k);
            tick();
        end
        check_eq("t5_pre_ovalid", c_ov, 1);
        check_eq("t5_pre_odata", c_od, 8'h32);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_ovalid", c_ov, 0);
        check_eq("t5_rst_odata", c_od, 0);
        check_eq("t5_rst_count", c_cnt, 0);
        check_eq("t5_rst_iready", c_ir, 1);
        c_iv = 0;
        tick();
        reset = 1'b0;
        tick();

        // T6: N=0 combinational pass-through
        for (int k = 0; k < 4; k++) begin
            z_iv = z_tv[k]; z_or = z_tr[k]; z_fl = z_tf[k]; z_id = z_td[k];
            #1;
            $display("z vec %0d data=0x%02h ovalid=%0b iready=%0b", k, z_od, z_ov, z_ir);
            check_eq("t6_odata", z_od, z_td[k]);
            check_eq("t6_ovalid", z_ov, z_eov[k]);
            check_eq("t6_iready", z_ir, z_eir[k]);
            check_eq("t6_count", z_cnt, 0);
        end

        check_eq("sb_a_empty", a_q.size(), 0);
        check_eq("sb_b_empty", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
